timer_irq_servicer: RTL and testbench

- Avalon-MM master that drives the 16-bit-halfword interval-timer slave without CPU involvement.
- On command it programs the 64-bit period, then starts the timer in continuous mode with interrupts enabled.
- On each timer irq it clears the status, snapshots the counter and reads the snapshot back, then emits a game-tick pulse with a running tick count.
- Sits between the game-logic clock domain (same clock) and the timer's s1 port.

---
 rtl/timer_irq_servicer.sv | 188 ++++++++++++++++++
 tb/tb_timer_irq_servicer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_servicer.sv
// Avalon-MM master that programs a 16-bit-halfword interval timer, starts it in
// continuous mode, and services each timeout: clear status, optional counter
// snapshot + readback, then a one-cycle game tick with a running tick count.
module timer_irq_servicer #(
   parameter logic [3:0]  CTRL_RUN_VALUE  = 4'h7,
   parameter logic [3:0]  CTRL_STOP_VALUE = 4'h8,
   parameter int unsigned READ_LATENCY    = 1,
   parameter bit          SNAP_ENABLE     = 1'b1,
   parameter int unsigned TICK_W          = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic [63:0]       cfg_period,
   output logic              busy,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic [63:0]       snapshot,
   output logic              snapshot_valid,
   output logic [3:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              timer_irq
);

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_WR_PERIOD  = 4'd1;
   localparam logic [3:0] ST_WR_CTRL    = 4'd2;
   localparam logic [3:0] ST_RUN        = 4'd3;
   localparam logic [3:0] ST_CLR_STATUS = 4'd4;
   localparam logic [3:0] ST_SNAP       = 4'd5;
   localparam logic [3:0] ST_READ       = 4'd6;
   localparam logic [3:0] ST_TICK       = 4'd7;
   localparam logic [3:0] ST_WR_STOP    = 4'd8;

   localparam logic [3:0] LAT = 4'(READ_LATENCY);

   logic [3:0]        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        lat_q, lat_d;
   logic [63:0]       period_q, period_d;
   logic [63:0]       shadow_q, shadow_d;
   logic [63:0]       snapshot_q, snapshot_d;
   logic [TICK_W-1:0] tick_count_q, tick_count_d;
   logic              stop_pending_q, stop_pending_d;

   // State and datapath registers; reset returns straight to IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= 2'd0;
         lat_q          <= 4'd0;
         period_q       <= 64'd0;
         shadow_q       <= 64'd0;
         snapshot_q     <= 64'd0;
         tick_count_q   <= '0;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         lat_q          <= lat_d;
         period_q       <= period_d;
         shadow_q       <= shadow_d;
         snapshot_q     <= snapshot_d;
         tick_count_q   <= tick_count_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   // Sequencer next-state logic.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      lat_d          = lat_q;
      period_d       = period_q;
      shadow_d       = shadow_q;
      snapshot_d     = snapshot_q;
      tick_count_d   = tick_count_q;
      stop_pending_d = stop_pending_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               period_d     = cfg_period;
               tick_count_d = '0;
               idx_d        = 2'd0;
               state_d      = ST_WR_PERIOD;
            end
         end
         ST_WR_PERIOD: begin
            idx_d = idx_q + 2'd1;
            // Period writes force-stop the timer, so control must come last.
            if (idx_q == 2'd3) state_d = ST_WR_CTRL;
         end
         ST_WR_CTRL: state_d = ST_RUN;
         ST_RUN: begin
            if (cfg_stop || stop_pending_q) state_d = ST_WR_STOP;
            else if (timer_irq)             state_d = ST_CLR_STATUS;
         end
         ST_CLR_STATUS: state_d = SNAP_ENABLE ? ST_SNAP : ST_TICK;
         ST_SNAP: begin
            idx_d   = 2'd0;
            lat_d   = 4'd0;
            state_d = ST_READ;
         end
         ST_READ: begin
            if (lat_q == LAT) begin
               shadow_d[{idx_q, 4'b0000} +: 16] = avm_readdata;
               lat_d = 4'd0;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = ST_TICK;
            end else begin
               lat_d = lat_q + 4'd1;
            end
         end
         ST_TICK: state_d = ST_RUN;
         ST_WR_STOP: begin
            stop_pending_d = 1'b0;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A stop mid-sequence is deferred until RUN so the service completes.
      if (cfg_stop && (state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_WR_STOP)) begin
         stop_pending_d = 1'b1;
      end

      // Load count/snapshot on entry so they are valid alongside the tick pulse.
      if (state_d == ST_TICK) begin
         tick_count_d = tick_count_q + 1'b1;
         if (SNAP_ENABLE) snapshot_d = shadow_d;
      end
   end

   // Moore bus and status outputs decoded from the current state.
   always_comb begin
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_address    = 4'd0;
      avm_writedata  = 16'd0;
      case (state_q)
         ST_WR_PERIOD: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = 4'd2 + {2'b00, idx_q};
            avm_writedata  = period_q[{idx_q, 4'b0000} +: 16];
         end
         ST_WR_CTRL: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = 4'd1;
            avm_writedata  = {12'b0, CTRL_RUN_VALUE};
         end
         ST_CLR_STATUS: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = 4'd0;
         end
         ST_SNAP: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = 4'd6;
         end
         ST_READ: begin
            avm_chipselect = (lat_q == 4'd0);
            avm_address    = 4'd6 + {2'b00, idx_q};
         end
         ST_WR_STOP: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = 4'd1;
            avm_writedata  = {12'b0, CTRL_STOP_VALUE};
         end
         default: ;
      endcase
   end

   assign busy           = (state_q != ST_IDLE);
   assign tick           = (state_q == ST_TICK);
   assign snapshot_valid = SNAP_ENABLE && (state_q == ST_TICK);
   assign tick_count     = tick_count_q;
   assign snapshot       = snapshot_q;

endmodule

// File: tb/tb_timer_irq_servicer.sv
// Bench for timer_irq_servicer: a behavioural timer slave, bus/tick monitors, and
// directed steps with randomised periods and counter values.
module tb_timer_irq_servicer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        cfg_start_a, cfg_stop_a, cfg_start_b, cfg_stop_b;
   logic [63:0] cfg_period;
   logic        irq_a, irq_b;
   logic [15:0] rdata = 16'h0;

   logic        busy_a, tick_a, sv_a, cs_a, wn_a;
   logic [31:0] tc_a;
   logic [63:0] snap_a;
   logic [3:0]  addr_a;
   logic [15:0] wd_a;
   logic        busy_b, tick_b, sv_b, cs_b, wn_b;
   logic [31:0] tc_b;
   logic [63:0] snap_b;
   logic [3:0]  addr_b;
   logic [15:0] wd_b;

   timer_irq_servicer dut_a (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start_a), .cfg_stop(cfg_stop_a),
      .cfg_period(cfg_period), .busy(busy_a), .tick(tick_a), .tick_count(tc_a),
      .snapshot(snap_a), .snapshot_valid(sv_a), .avm_address(addr_a),
      .avm_chipselect(cs_a), .avm_write_n(wn_a), .avm_writedata(wd_a),
      .avm_readdata(rdata), .timer_irq(irq_a)
   );

   timer_irq_servicer #(.SNAP_ENABLE(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start_b), .cfg_stop(cfg_stop_b),
      .cfg_period(cfg_period), .busy(busy_b), .tick(tick_b), .tick_count(tc_b),
      .snapshot(snap_b), .snapshot_valid(sv_b), .avm_address(addr_b),
      .avm_chipselect(cs_b), .avm_write_n(wn_b), .avm_writedata(wd_b),
      .avm_readdata(rdata), .timer_irq(irq_b)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sv_mis = 0;
   int svb_cnt = 0;

   logic [63:0] counter_val = 64'h0;
   logic [63:0] snap_reg = 64'h0;

   logic [3:0]  wa_q[$];
   logic [15:0] wd_q[$];
   int          wc_q[$];
   logic [3:0]  ra_q[$];
   int          tk_q[$];
   logic [3:0]  wab_q[$];
   logic [15:0] wdb_q[$];
   int          wcb_q[$];
   int          tkb_q[$];

   // Timer slave model: snapshot write captures the counter, reads registered.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cs_a && !wn_a && addr_a == 4'd6) snap_reg <= counter_val;
      if (cs_a && wn_a) begin
         case (addr_a)
            4'd6: rdata <= snap_reg[15:0];
            4'd7: rdata <= snap_reg[31:16];
            4'd8: rdata <= snap_reg[47:32];
            4'd9: rdata <= snap_reg[63:48];
            default: rdata <= 16'hxxxx;
         endcase
      end
   end

   // Bus and tick monitors.
   always @(negedge clk) begin
      if (cs_a && !wn_a) begin
         wa_q.push_back(addr_a); wd_q.push_back(wd_a); wc_q.push_back(cyc);
      end
      if (cs_a && wn_a) ra_q.push_back(addr_a);
      if (tick_a) tk_q.push_back(cyc);
      if (tick_a !== sv_a) sv_mis++;
      if (cs_b && !wn_b) begin
         wab_q.push_back(addr_b); wdb_q.push_back(wd_b); wcb_q.push_back(cyc);
      end
      if (tick_b) tkb_q.push_back(cyc);
      if (sv_b) svb_cnt++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int which);
      case (which)
         0: return wa_q.size();
         1: return ra_q.size();
         2: return tk_q.size();
         3: return wab_q.size();
         default: return tkb_q.size();
      endcase
   endfunction

   task automatic wait_until(input int which, input int n, input string tag);
      int b = 0;
      while (qsize(which) < n && b < 60) begin
         step();
         b++;
      end
      check({tag, "_timeout"}, 64'(qsize(which) >= n), 64'd1);
   endtask

   task automatic clear_q();
      wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); tk_q.delete();
      wab_q.delete(); wdb_q.delete(); wcb_q.delete(); tkb_q.delete();
   endtask

   // Raise irq on A and drop it once the status-clear write is seen.
   task automatic serve_a();
      int b = 0;
      irq_a = 1'b1;
      while (!(cs_a && !wn_a && addr_a == 4'd0) && b < 20) begin
         step();
         b++;
      end
      irq_a = 1'b0;
      check("irq_clear_seen", 64'(cs_a && !wn_a && addr_a == 4'd0), 64'd1);
   endtask

   task automatic start_a(input logic [63:0] p);
      cfg_period  = p;
      cfg_start_a = 1'b1;
      step();
      cfg_start_a = 1'b0;
   endtask

   initial begin
      logic [63:0] per, per2;
      int exp_count;
      logic [3:0]  exp_addr[5];
      logic [15:0] exp_data[5];

      reset_n = 1'b0;
      cfg_start_a = 0; cfg_stop_a = 0; cfg_start_b = 0; cfg_stop_b = 0;
      cfg_period = 64'h0; irq_a = 0; irq_b = 0;
      step(); step(); step();
      check("rst_busy", busy_a, 0);
      check("rst_cs", cs_a, 0);
      check("rst_write_n", wn_a, 1);
      check("rst_addr", addr_a, 0);
      check("rst_wdata", wd_a, 0);
      check("rst_tick", tick_a, 0);
      check("rst_snap_valid", sv_a, 0);
      check("rst_tick_count", tc_a, 0);
      check("rst_snapshot", snap_a, 0);
      reset_n = 1'b1;
      step();

      // Program + start; a second start while busy must not relatch.
      clear_q();
      per = 64'h63;
      start_a(per);
      check("busy_after_start", busy_a, 1);
      cfg_period  = 64'hDEAD_BEEF_CAFE_F00D;
      cfg_start_a = 1'b1;
      step();
      cfg_start_a = 1'b0;
      wait_until(0, 5, "prog_writes");
      for (int i = 0; i < 4; i++) begin
         exp_addr[i] = 4'(2 + i);
         exp_data[i] = 16'((per >> (16 * i)) & 64'hFFFF);
      end
      exp_addr[4] = 4'd1;
      exp_data[4] = 16'h0007;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("prog_addr%0d", i), wa_q[i], exp_addr[i]);
         check($sformatf("prog_data%0d", i), wd_q[i], exp_data[i]);
      end
      check("ctrl_follows_period", 64'(wc_q[4] - wc_q[3]), 64'd1);
      check("ctrl_after_start_cycles", 64'(wc_q[4] - wc_q[0]), 64'd4);
      step();
      check("run_bus_idle", cs_a, 0);

      // Serviced timeouts with random counter values.
      exp_count = 0;
      for (int s = 0; s < 5; s++) begin
         counter_val = (s == 0) ? 64'h1234 : {$urandom, $urandom};
         clear_q();
         serve_a();
         wait_until(2, 1, "svc_tick");
         exp_count++;
         check("svc_tick", tick_a, 1);
         check("svc_snap_valid", sv_a, 1);
         check("svc_snapshot", snap_a, counter_val);
         check("svc_tick_count", tc_a, 64'(exp_count));
         check("svc_nwrites", 64'(wa_q.size()), 2);
         check("svc_clr_addr", wa_q[0], 0);
         check("svc_clr_data", wd_q[0], 0);
         check("svc_snap_addr", wa_q[1], 6);
         check("svc_nreads", 64'(ra_q.size()), 4);
         for (int i = 0; i < 4; i++) check("svc_read_addr", ra_q[i], 64'(6 + i));
         if (s == 0) check("svc_duration", 64'(tk_q[0] - wc_q[0]), 64'd10);
         step();
         check("svc_tick_off", tick_a, 0);
      end

      // Stop during READ index 2: service completes, then stop write.
      counter_val = {$urandom, $urandom};
      clear_q();
      serve_a();
      wait_until(1, 3, "rd2");
      cfg_stop_a = 1'b1;
      step();
      cfg_stop_a = 1'b0;
      wait_until(2, 1, "stop_tick");
      exp_count++;
      check("stop_tick_count", tc_a, 64'(exp_count));
      check("stop_snapshot", snap_a, counter_val);
      wait_until(0, 3, "stop_write");
      check("stop_addr", wa_q[2], 1);
      check("stop_data", wd_q[2], 16'h0008);
      check("stop_after_tick", 64'(wc_q[2] - tk_q[0]), 64'd2);
      check("stop_busy_hi", busy_a, 1);
      step();
      check("stop_busy_lo", busy_a, 0);

      // Stop and irq in the same RUN cycle: stop wins, no tick.
      clear_q();
      per2 = {$urandom, $urandom};
      start_a(per2);
      wait_until(0, 5, "prog2");
      for (int i = 0; i < 4; i++)
         check("prog2_data", wd_q[i], 64'((per2 >> (16 * i)) & 64'hFFFF));
      step();
      clear_q();
      cfg_stop_a = 1'b1;
      irq_a = 1'b1;
      step();
      cfg_stop_a = 1'b0;
      step();
      step();
      irq_a = 1'b0;
      check("race_nwrites", 64'(wa_q.size()), 1);
      check("race_addr", wa_q[0], 1);
      check("race_data", wd_q[0], 16'h0008);
      check("race_no_tick", 64'(tk_q.size()), 0);
      check("race_tick_count", tc_a, 0);
      check("race_busy", busy_a, 0);

      // Snapshot disabled instance.
      clear_q();
      cfg_period  = {$urandom, $urandom};
      cfg_start_b = 1'b1;
      step();
      cfg_start_b = 1'b0;
      check("b_busy", busy_b, 1);
      wait_until(3, 5, "b_prog");
      step();
      clear_q();
      irq_b = 1'b1;
      for (int b = 0; b < 20 && !(cs_b && !wn_b && addr_b == 4'd0); b++) step();
      irq_b = 1'b0;
      wait_until(4, 1, "b_tick");
      check("b_nwrites", 64'(wab_q.size()), 1);
      check("b_clr_addr", wab_q[0], 0);
      check("b_tick_delay", 64'(tkb_q[0] - wcb_q[0]), 64'd1);
      check("b_snapshot", snap_b, 0);
      check("b_snap_valid", sv_b, 0);
      check("b_tick_count", tc_b, 1);

      // Asynchronous reset during WR_PERIOD index 2.
      clear_q();
      start_a({$urandom, $urandom});
      for (int b = 0; b < 10 && !(cs_a && addr_a == 4'd4); b++) step();
      check("mid_reset_at_idx2", 64'(cs_a && addr_a == 4'd4), 64'd1);
      reset_n = 1'b0;
      #1;
      check("arst_cs", cs_a, 0);
      check("arst_write_n", wn_a, 1);
      check("arst_busy", busy_a, 0);
      step();
      reset_n = 1'b1;
      step();
      clear_q();
      per2 = {$urandom, $urandom};
      start_a(per2);
      wait_until(0, 1, "restart");
      check("restart_addr", wa_q[0], 2);
      check("restart_data", wd_q[0], per2[15:0]);

      check("tick_snapvalid_coincident", 64'(sv_mis), 0);
      check("b_snapvalid_never", 64'(svb_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
